hazard_ctrl: RTL

Pipeline control unit for the 5-stage core (IF, ID, EX, MEM, WB). It drives the `en` and `flush` inputs of every inter-stage pipeline register and the PC enable. It resolves load-use hazards, branch/jump redirects, data-memory wait states and multicycle EX operations, and holds the pipeline in bubbles for one cycle after reset.

---
 rtl/hazard_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline control for the 5-stage core (IF, ID, EX, MEM, WB).
// Drives the enable/flush pair of every inter-stage register plus the PC
// enable. Resolves data-memory wait states, multicycle EX ops, branch/jump
// redirects and load-use hazards, and holds bubbles for one cycle after reset.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> 32-bit stall/redirect performance counters are built
//   undefined -> stall_cnt and redir_cnt are tied to zero, no counter flops
module hazard_ctrl #(
  parameter int REG_W  = 5,
  parameter int MC_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             ex_mc_start,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             mc_done,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      redir_cnt
);

  localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  // Number of MC_WAIT cycles that follow the start cycle.
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 2);

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_RUN     = 2'd1,
    S_MC_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mc_done;

  logic w_load_use;
  logic w_mc_start;
  logic w_mc_hold;

  // Load in EX whose destination feeds a source the ID instruction reads.
  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign w_load_use = ex_is_load && (ex_rd != '0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

  // A multicycle op starts only in RUN; while mc_done is set the op that
  // just finished is leaving EX, so its still-asserted start is ignored.
  assign w_mc_start = (r_state == S_RUN) && ex_mc_start && !r_mc_done;
  assign w_mc_hold  = (r_state == S_MC_WAIT) || w_mc_start;

  assign mc_done = r_mc_done;

  // Enable/flush decode: fixed priority busy > multicycle > redirect > load-use.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    if (r_state == S_INIT) begin
      // Fill every stage with bubbles while nothing advances.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_busy) begin
      // Whole pipeline frozen; EX requests persist and are served afterwards.
      pc_en = 1'b0;
    end else if (w_mc_hold) begin
      // IF/ID/EX frozen on the multicycle op; MEM receives bubbles, WB drains.
      ex_mem_en    = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_en    = 1'b1;
    end else if (ex_redirect) begin
      // Squash the two younger instructions; load-use is moot for them.
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_load_use) begin
      // Hold IF and ID one cycle and insert a single bubble into EX.
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
    end
  end

  // Control FSM. In MC_WAIT, r_cnt holds the number of wait cycles still to
  // run including the current one, so the op occupies EX for exactly MC_LAT
  // cycles: start, MC_LAT-2 waits, then the mc_done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_INIT;
      r_cnt     <= '0;
      r_mc_done <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (!mem_busy) begin
            r_mc_done <= 1'b0;
            if (w_mc_start) begin
              if (MC_LAT <= 2) begin
                // No wait cycles: the next cycle is already the final one.
                r_mc_done <= 1'b1;
              end else begin
                r_state <= S_MC_WAIT;
                r_cnt   <= MC_LOAD;
              end
            end
          end
        end
        S_MC_WAIT: begin
          if (!mem_busy) begin
            if (r_cnt <= CNT_W'(1)) begin
              r_state   <= S_RUN;
              r_cnt     <= '0;
              r_mc_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_redir_cnt;
  logic        w_active;
  logic        w_redir_take;

  assign w_active     = (r_state != S_INIT);
  // Redirect counts only when it actually wins the priority decode.
  assign w_redir_take = w_active && !mem_busy && !w_mc_hold && ex_redirect;

  // Performance counters: stalled fetch cycles and honored redirects; wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_redir_cnt <= '0;
    end else if (w_active) begin
      if (!pc_en) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_redir_take) begin
        r_redir_cnt <= r_redir_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign redir_cnt = r_redir_cnt;
`else
  assign stall_cnt = '0;
  assign redir_cnt = '0;
`endif

endmodule
